// File: rtl/div_sched.sv
// Programmable period scheduler: issues a one-cycle tick every R clocks with IDLE/RUN/HALT control.
// Optional DIV_SCHED_TOGGLE_EN adds a registered div_clock that toggles on every tick.
module div_sched #(
  parameter int unsigned CNT_W     = 17,
  parameter int unsigned TCNT_W    = 8,
  parameter int unsigned DEF_RATIO = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_ratio,
  output logic              cfg_ready,
  output logic              tick,
  output logic              div_clock,
  output logic              busy,
  output logic [TCNT_W-1:0] tick_count,
  output logic [1:0]        state_dbg
);

  // cfg handshake: a ratio transfers on a rising edge where cfg_valid && cfg_ready;
  // cfg_valid may be held, cfg_ratio must be stable while cfg_valid is high.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   ratio;
  logic [CNT_W-1:0]   pend_ratio;
  logic               pend_valid;
  logic [CNT_W-1:0]   cnt_last;
  logic               cfg_accept;
  logic               launch;

  // A ratio of 0 behaves like 1, so the terminal count is 0 for both.
  assign cnt_last   = (ratio == '0) ? '0 : ratio - 1'b1;
  assign tick       = (state != IDLE) && (cnt == cnt_last);
  assign busy       = (state != IDLE);
  assign cfg_ready  = (state == IDLE) || !pend_valid;
  assign cfg_accept = cfg_valid && cfg_ready;
  assign launch     = (state == IDLE) && (state_nxt == RUN);
  assign state_dbg  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !stop) state_nxt = RUN;
      RUN:  if (stop) state_nxt = HALT;
      HALT: begin
        if (start && !stop) state_nxt = RUN;
        else if (tick)      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                               cnt <= '0;
    else if (launch || state_nxt == IDLE || tick) cnt <= '0;
    else                                      cnt <= cnt + 1'b1;
  end

  // While a period is running, new ratios wait in pend_ratio until the terminal count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ratio      <= CNT_W'(DEF_RATIO);
      pend_ratio <= '0;
      pend_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (cfg_accept) ratio <= cfg_ratio;
    end else begin
      if (tick && pend_valid) begin
        ratio      <= pend_ratio;
        pend_valid <= 1'b0;
      end
      if (cfg_accept) begin
        pend_ratio <= cfg_ratio;
        pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      tick_count <= '0;
    else if (launch) tick_count <= '0;
    else if (tick)   tick_count <= tick_count + 1'b1;
  end

`ifdef DIV_SCHED_TOGGLE_EN
  logic div_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      div_q <= 1'b0;
    else if (launch) div_q <= 1'b0;
    else if (tick)   div_q <= ~div_q;
  end

  assign div_clock = div_q;
`else
  assign div_clock = 1'b0;
`endif

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter: CNT_W, 17, width of period counter and ratio register.
REQ-002 SHALL have parameter: TCNT_W, 8, width of tick_count.
REQ-003 SHALL have parameter: DEF_RATIO, 100000, ratio loaded at reset (must fit in CNT_W).
REQ-004 SHALL have port: clock  in  1  single system clock; all state on rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: start  in  1  level-sampled run request.
REQ-007 SHALL have port: stop  in  1  level-sampled stop request.
REQ-008 SHALL have port: cfg_valid  in  1  new ratio offered.
REQ-009 SHALL have port: cfg_ratio  in  CNT_W  offered period in clock cycles.
REQ-010 SHALL have port: cfg_ready  out  1  ratio accepted when cfg_valid&&cfg_ready at an edge.
REQ-011 SHALL have port: tick  out  1  one-cycle enable pulse, once per period.
REQ-012 SHALL have port: div_clock  out  1  divided square wave (see Configuration).
REQ-013 SHALL have port: busy  out  1  high whenever state != IDLE.
REQ-014 SHALL have port: tick_count  out  TCNT_W  ticks issued since last start.

Function
REQ-015 SHALL implement states IDLE, RUN, HALT.
REQ-016 SHALL transition IDLE->RUN on start=1 && stop=0; simultaneous start&stop in IDLE SHALL remain IDLE.
REQ-017 SHALL transition RUN->HALT on stop=1 (start ignored in RUN).
REQ-018 SHALL, in HALT, keep counting, issue the final tick at terminal count, then enter IDLE the following cycle; start=1 && stop=0 in HALT SHALL return to RUN without resetting the counter.
REQ-019 SHALL clear the period counter and tick_count on the IDLE->RUN edge; counter reads 0 in the first RUN cycle.
REQ-020 SHALL count 0..R-1 in RUN/HALT and wrap to 0; terminal count is cnt==R-1; effective R = max(ratio,1), so ratio 0 behaves as 1 (tick every cycle).
REQ-021 SHALL assert tick combinationally for exactly the cycle where cnt==R-1 in RUN/HALT; start sampled at edge k SHALL yield the first tick in cycle k+R.
REQ-022 SHALL hold counter at 0 and tick=0 in IDLE.
REQ-023 SHALL increment tick_count on each tick, wrapping 2^TCNT_W-1 -> 0.
REQ-024 SHALL hold cfg_ready=1 in IDLE and write accepted cfg_ratio to the ratio register directly.
REQ-025 SHALL, in RUN/HALT, capture an accepted ratio into a pending register, drop cfg_ready until applied, and apply it at the next terminal count so the following period uses the new R.
REQ-026 SHALL, when a pending ratio exists on RUN/HALT->IDLE, apply it on that transition edge.
REQ-027 SHALL never change the current period length mid-period.

Reset
REQ-028 SHALL, on reset=0, asynchronously force: state IDLE, counter 0, ratio DEF_RATIO, pending cleared, tick_count 0, div_clock 0, busy 0, cfg_ready 1 once reset released.
REQ-029 SHALL abort any period in progress on reset assertion mid-RUN with no tick emitted.

Configuration
REQ-030 SHALL, with DIV_SCHED_TOGGLE_EN defined, toggle div_clock registered on every tick (period 2R cycles, cleared on IDLE->RUN).
REQ-031 SHALL, without DIV_SCHED_TOGGLE_EN, tie div_clock to 0 and omit its flop; all other behaviour unchanged.

Verification
REQ-032 SHALL cover: reset, cfg ratio=4 in IDLE, start pulse at edge 0 -> ticks in cycles 4,8,12; tick_count 1,2,3.
REQ-033 SHALL cover: ratio=5 running, cfg_valid ratio=3 accepted mid-period -> cfg_ready low until next tick; following ticks spaced 3.
REQ-034 SHALL cover: ratio=4, stop at cycle 6 -> HALT, final tick cycle 8, busy low from cycle 9, no further ticks.
REQ-035 SHALL cover: ratio=0 and ratio=1 -> tick every RUN cycle; 256 ticks with TCNT_W=8 -> tick_count wraps to 0.
REQ-036 SHALL cover: reset asserted mid-period at ratio=10 -> outputs at reset values immediately, ratio back to DEF_RATIO.
REQ-037 SHALL cover: start&stop both high in IDLE -> remains IDLE; with DIV_SCHED_TOGGLE_EN and ratio=2 -> div_clock period 4 cycles.
